// File: rtl/fpp_reg_ctrl.sv
// fpp_reg_ctrl: half-precision register file and issue controller feeding
// the FPP_16bALU. Optional status flags under `FPP_STATUS_FLAGS_EN.
//
// Ports:
//   clk, rst (async, active-low)
//   instr/instr_data/instr_valid/instr_ready : instruction handshake
//   alu_st/alu_func/alu_data/alu_rega/alu_regb : ALU drive
//   alu_regout/alu_en/alu_flag_io              : ALU result/done/store flag
//   io_out/io_valid                            : STORE result port
//   err_illegal/err_timeout                    : one-cycle error pulses
//   dbg_addr/dbg_data                          : combinational regfile peek
//   flag_zero/flag_neg                         : write-back status flags
module fpp_reg_ctrl #(
  parameter int NREGS   = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic [15:0]       instr_data,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              alu_st,
  output logic [3:0]        alu_func,
  output logic [15:0]       alu_data,
  output logic [15:0]       alu_rega,
  output logic [15:0]       alu_regb,
  input  logic [15:0]       alu_regout,
  input  logic              alu_en,
  input  logic              alu_flag_io,
  output logic [15:0]       io_out,
  output logic              io_valid,
  output logic              err_illegal,
  output logic              err_timeout,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [15:0]       dbg_data,
  output logic              flag_zero,
  output logic              flag_neg
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, WRITE
  } state_t;

  state_t state, state_d;

  logic [15:0]       regs [NREGS];
  logic [ADDR_W-1:0] dest_q;
  logic [15:0]       result_q;
  logic [CW-1:0]     cnt;
  logic              en_q;

  logic [3:0] op;
  logic       is_alu;
  logic       is_clr;
  logic       accept;
  logic       done;
  logic       tmo;
  logic       store;
  logic       unused_ok;

  assign op        = instr[15:12];
  assign unused_ok = &{1'b0, instr[2:0]};

  always_comb begin
    is_alu = 1'b0;
    is_clr = 1'b0;
    unique case (1'b1)
      (op[3] == 1'b0),
      (op == 4'h8): is_alu = 1'b1;
      (op == 4'h9): is_clr = 1'b1;
      default: ;
    endcase
  end

  assign instr_ready = (state == IDLE);
  assign alu_st      = (state == ISSUE);
  assign accept      = instr_ready & instr_valid;

  // Only a fresh rising edge of alu_en counts; a level left high by the
  // previous op must not complete the current one.
  assign done  = (state == WAIT) & alu_en & ~en_q;
  assign tmo   = (state == WAIT) & ~done
               & (cnt == CW'(TIMEOUT - 1));
  assign store = done & alu_flag_io;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept && is_alu)      state_d = ISSUE;
        else if (accept && is_clr) state_d = WRITE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done)     state_d = alu_flag_io ? IDLE : WRITE;
        else if (tmo) state_d = IDLE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dest_q      <= '0;
      result_q    <= '0;
      alu_func    <= '0;
      alu_data    <= '0;
      alu_rega    <= '0;
      alu_regb    <= '0;
      cnt         <= '0;
      en_q        <= 1'b0;
      io_out      <= '0;
      io_valid    <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      en_q        <= alu_en;
      io_valid    <= store;
      err_illegal <= accept & ~is_alu & ~is_clr;
      err_timeout <= tmo;
      if (accept) begin
        dest_q   <= ADDR_W'(instr[11:9]);
        alu_func <= op;
        alu_rega <= regs[ADDR_W'(instr[8:6])];
        alu_regb <= regs[ADDR_W'(instr[5:3])];
        alu_data <= instr_data;
        result_q <= '0;
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT)  cnt <= cnt + 1'b1;
      if (done && !alu_flag_io) result_q <= alu_regout;
      if (store) io_out <= alu_regout;
      if (state == WRITE) regs[dest_q] <= result_q;
    end
  end

  assign dbg_data = regs[dbg_addr];

`ifdef FPP_STATUS_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
    end else if (state == WRITE) begin
      flag_zero <= (result_q[14:0] == 15'd0);
      flag_neg  <= result_q[15];
    end
  end
`else
  assign flag_zero = 1'b0;
  assign flag_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_fpp_reg_ctrl.sv
// tb_fpp_reg_ctrl: scoreboard bench for fpp_reg_ctrl with a stub ALU
// and a behavioural register-file model.
module tb_fpp_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = '0;
  logic [15:0] instr_data = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        alu_st;
  logic [3:0]  alu_func;
  logic [15:0] alu_data, alu_rega, alu_regb;
  logic [15:0] alu_regout = '0;
  logic        alu_en = 1'b0;
  logic        alu_flag_io = 1'b0;
  logic [15:0] io_out;
  logic        io_valid, err_illegal, err_timeout;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  logic        flag_zero, flag_neg;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  fpp_reg_ctrl dut (
    .clk(clk), .rst(rst),
    .instr(instr), .instr_data(instr_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_st(alu_st), .alu_func(alu_func), .alu_data(alu_data),
    .alu_rega(alu_rega), .alu_regb(alu_regb),
    .alu_regout(alu_regout), .alu_en(alu_en),
    .alu_flag_io(alu_flag_io),
    .io_out(io_out), .io_valid(io_valid),
    .err_illegal(err_illegal), .err_timeout(err_timeout),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .flag_zero(flag_zero), .flag_neg(flag_neg)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Stand-in ALU behaviour; opcode 8 is the STORE that raises flag_io.
  function automatic logic [15:0] alu_fn(input logic [3:0] f,
      input logic [15:0] d, input logic [15:0] a, input logic [15:0] b);
    case (f)
      4'h0: return d;
      4'h1: return (a == b) ? a + 16'h0400 : a + b;
      4'h2: return a - b;
      4'h3: return a ^ b;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ 16'h8000;
      default: return a;
    endcase
  endfunction

  // Stub ALU: keeps alu_en at its old level for a while (stale),
  // drops it, then raises it with the result.
  logic hang = 1'b0;
  always @(negedge clk) begin : stub
    logic [15:0] r, a0;
    logic [3:0]  f;
    int k0, gap;
    if (rst && alu_st && !hang) begin
      f  = alu_func;
      a0 = alu_rega;
      r  = alu_fn(alu_func, alu_data, alu_rega, alu_regb);
      k0  = $urandom_range(1, 3);
      gap = $urandom_range(1, 3);
      repeat (k0) @(negedge clk);
      alu_en      = 1'b0;
      alu_regout  = r;
      alu_flag_io = (f == 4'h8);
      repeat (gap) @(negedge clk);
      chk("hold_func", {28'd0, alu_func}, {28'd0, f});
      chk("hold_rega", {16'd0, alu_rega}, {16'd0, a0});
      alu_en = 1'b1;
    end
  end

  // Reference model and scoreboard.
  typedef struct {
    int              kind; // 0 write, 1 store, 2 timeout, 3 illegal
    logic [15:0]     io;
    logic [7:0][15:0] r;
    logic            z;
    logic            n;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m [8];
  logic        mz = 1'b0, mn = 1'b0;
  int          exp_st = 0;
  int          seen_st = 0;

  task automatic mwrite(input logic [2:0] d, input logic [15:0] v);
    m[d] = v;
    mz = (v[14:0] == 15'd0);
    mn = v[15];
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] d,
      input logic [2:0] a, input logic [2:0] b,
      input logic [15:0] data, input logic hg);
    exp_t e;
    logic [15:0] res;
    int cyc;
    cyc = 0;
    while (!instr_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    hang = hg;
    e.io = '0;
    if (op <= 4'h8) begin
      exp_st++;
      if (hg) e.kind = 2;
      else begin
        res = alu_fn(op, data, m[a], m[b]);
        if (op == 4'h8) begin
          e.kind = 1;
          e.io = res;
        end else begin
          e.kind = 0;
          mwrite(d, res);
        end
      end
    end else if (op == 4'h9) begin
      e.kind = 0;
      mwrite(d, 16'h0000);
    end else e.kind = 3;
    for (int i = 0; i < 8; i++) e.r[i] = m[i];
`ifdef FPP_STATUS_FLAGS_EN
    e.z = mz;
    e.n = mn;
`else
    e.z = 1'b0;
    e.n = 1'b0;
`endif
    sb.push_back(e);
    instr = {op, d, a, b, 3'b000};
    instr_data = data;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 16'($urandom);
    instr_data = 16'($urandom);
    cyc = 0;
    while (!instr_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_return", {31'd0, cyc < 300}, 32'd1);
    if (op == 4'h9) chk("clr_latency", cyc, 1);
    if (op <= 4'h8 && hg) chk("timeout_latency", cyc, 65);
  endtask

  // Monitor: pops one expectation per completed instruction.
  logic rdy_prev = 1'b1;
  always @(negedge clk) begin : mon
    exp_t e;
    logic rise;
    if (rst && alu_st) seen_st++;
    rise = instr_ready && !rdy_prev;
    rdy_prev = instr_ready;
    if (rst && (rise || err_illegal || io_valid || err_timeout)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("err_illegal", {31'd0, err_illegal}, {31'd0, e.kind == 3});
        chk("err_timeout", {31'd0, err_timeout}, {31'd0, e.kind == 2});
        chk("io_valid", {31'd0, io_valid}, {31'd0, e.kind == 1});
        if (e.kind == 1) chk("io_out", {16'd0, io_out}, {16'd0, e.io});
        chk("flag_zero", {31'd0, flag_zero}, {31'd0, e.z});
        chk("flag_neg", {31'd0, flag_neg}, {31'd0, e.n});
        for (int i = 0; i < 8; i++) begin
          dbg_addr = 3'(i);
          #1;
          chk($sformatf("reg%0d", i), {16'd0, dbg_data}, {16'd0, e.r[i]});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    logic       hg;
    for (int i = 0; i < 8; i++) m[i] = '0;
    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_st", {31'd0, alu_st}, 32'd0);
    chk("rst_func", {28'd0, alu_func}, 32'd0);
    chk("rst_io", {16'd0, io_out}, 32'd0);
    chk("rst_dbg", {16'd0, dbg_data}, 32'd0);
    #3 rst = 1'b1;
    @(negedge clk);

    issue(4'h0, 3'd1, 3'd0, 3'd0, 16'h3C00, 1'b0);
    issue(4'h1, 3'd2, 3'd1, 3'd1, 16'h1111, 1'b0);
    chk("add_result_model", {16'd0, m[2]}, 32'h4000);
    issue(4'h8, 3'd0, 3'd2, 3'd0, 16'h0000, 1'b0);
    issue(4'h9, 3'd2, 3'd0, 3'd0, 16'h0000, 1'b0);
    issue(4'h7, 3'd3, 3'd1, 3'd0, 16'h0000, 1'b1);
    issue(4'hF, 3'd4, 3'd1, 3'd1, 16'h0000, 1'b0);
    issue(4'hA, 3'd5, 3'd1, 3'd1, 16'h0000, 1'b0);
    issue(4'h6, 3'd6, 3'd1, 3'd1, 16'h0000, 1'b0);

    // Reset while an op sits in WAIT.
    hang = 1'b1;
    exp_st++;
    instr = {4'h0, 3'd5, 3'd0, 3'd0, 3'd0};
    instr_data = 16'h1234;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (5) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("mid_rst_st", {31'd0, alu_st}, 32'd0);
    chk("mid_rst_func", {28'd0, alu_func}, 32'd0);
    chk("mid_rst_data", {16'd0, alu_data}, 32'd0);
    chk("mid_rst_rega", {16'd0, alu_rega}, 32'd0);
    chk("mid_rst_regb", {16'd0, alu_regb}, 32'd0);
    chk("mid_rst_io", {16'd0, io_out}, 32'd0);
    chk("mid_rst_flags", {30'd0, flag_zero, flag_neg}, 32'd0);
    chk("mid_rst_dbg", {16'd0, dbg_data}, 32'd0);
    for (int i = 0; i < 8; i++) m[i] = '0;
    mz = 1'b0;
    mn = 1'b0;
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    hang = 1'b0;
    repeat (10) @(negedge clk);
    issue(4'h0, 3'd5, 3'd0, 3'd0, 16'hBC00, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      hg = (op <= 4'h8) && ($urandom_range(0, 11) == 0);
      issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 16'($urandom), hg);
    end

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("st_count", seen_st, exp_st);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
